// File: rtl/lfsr_decrypt_depad.sv
// rtl/lfsr_decrypt_depad.sv - LFSR stream decrypter that strips a space preamble and pads output to MSG_LEN
//
// Optional feature macro: LFSR_AUTOSEED_EN (first character supplies the key instead of seed).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start / ack         level run request / run complete (high in DONE)
//   taps, seed          LFSR feedback mask and initial state, latched when a run starts
//   in_data/valid/ready ciphertext stream, MSB = parity bit over the payload
//   out_data/valid/ready decoded stream, MSB = parity-error flag
//   err_count           parity errors seen in the current/last run

module lfsr_decrypt_depad #(
    parameter int                DATA_W   = 8,
    parameter int                MSG_LEN  = 64,
    parameter logic [DATA_W-2:0] PAD_CHAR = 7'h20
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         ack,
    input  logic [DATA_W-2:0]            taps,
    input  logic [DATA_W-2:0]            seed,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(MSG_LEN+1)-1:0] err_count
);

    localparam int                LFSR_W    = DATA_W - 1;
    localparam int                CNT_W     = $clog2(MSG_LEN + 1);
    localparam logic [CNT_W-1:0]  MSG_LEN_C = CNT_W'(MSG_LEN);
    localparam logic [CNT_W-1:0]  LAST_C    = CNT_W'(MSG_LEN - 1);

    typedef enum logic [2:0] {IDLE, STRIP, PASS, FILL, DONE} state_t;

    state_t              state, state_nxt;
    logic [LFSR_W-1:0]   lfsr, taps_q, plain;
    logic [CNT_W-1:0]    in_cnt, out_cnt, emit_cnt;
    logic                out_free, accept, out_take, parity_err;
    logic                begin_run, last_in, drop, emit_in, emit_fill;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                     input logic [LFSR_W-1:0] t);
        return {s[LFSR_W-2:0], ^(s & t)};
    endfunction

    assign out_free   = !out_valid || out_ready;
    assign in_ready   = (state == STRIP || state == PASS) && (in_cnt < MSG_LEN_C) && out_free;
    assign accept     = in_valid && in_ready;
    assign out_take   = out_valid && out_ready;
    assign plain      = in_data[LFSR_W-1:0] ^ lfsr;
    assign parity_err = in_data[DATA_W-1] != ^in_data[LFSR_W-1:0];
    assign begin_run  = (state == IDLE || state == DONE) && start;
    assign last_in    = accept && (in_cnt == LAST_C);
    assign ack        = (state == DONE);

`ifdef LFSR_AUTOSEED_EN
    // The first accepted character carries the key: its payload XOR PAD_CHAR.
    logic              key_loaded, key_char;
    logic [LFSR_W-1:0] key0;
    assign key_char = accept && !key_loaded;
    assign key0     = ((in_data[LFSR_W-1:0] ^ PAD_CHAR) == '0) ? LFSR_W'(1)
                                                               : (in_data[LFSR_W-1:0] ^ PAD_CHAR);
    assign drop     = accept && (key_char ||
                      (state == STRIP && !parity_err && plain == PAD_CHAR));
`else
    assign drop     = accept && state == STRIP && !parity_err && plain == PAD_CHAR;
`endif

    assign emit_in   = accept && !drop;
    // Fill characters are only generated once input is exhausted and the output register is free.
    assign emit_fill = (state == FILL) && out_free && (emit_cnt < MSG_LEN_C);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = STRIP;
            STRIP: if (last_in) state_nxt = FILL;
                   else if (emit_in) state_nxt = PASS;
            PASS:  if (last_in) state_nxt = FILL;
            FILL:  if (out_take && out_cnt == LAST_C) state_nxt = DONE;
            DONE:  if (start) state_nxt = STRIP;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr      <= LFSR_W'(1);
            taps_q    <= '0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            emit_cnt  <= '0;
            err_count <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef LFSR_AUTOSEED_EN
            key_loaded <= 1'b0;
`endif
        end else if (begin_run) begin
`ifdef LFSR_AUTOSEED_EN
            lfsr       <= LFSR_W'(1);
            key_loaded <= 1'b0;
`else
            lfsr      <= (seed == '0) ? LFSR_W'(1) : seed;
`endif
            taps_q    <= taps;
            in_cnt    <= '0;
            out_cnt   <= '0;
            emit_cnt  <= '0;
            err_count <= '0;
        end else begin
            if (accept) begin
                in_cnt <= in_cnt + 1'b1;
`ifdef LFSR_AUTOSEED_EN
                if (key_char) begin
                    lfsr       <= lfsr_next(key0, taps_q);
                    key_loaded <= 1'b1;
                end else begin
                    lfsr <= lfsr_next(lfsr, taps_q);
                    if (parity_err && err_count != MSG_LEN_C) err_count <= err_count + 1'b1;
                end
`else
                lfsr <= lfsr_next(lfsr, taps_q);
                if (parity_err && err_count != MSG_LEN_C) err_count <= err_count + 1'b1;
`endif
            end
            if (out_take) out_cnt <= out_cnt + 1'b1;
            if (emit_in) begin
                out_data  <= {parity_err, plain};
                out_valid <= 1'b1;
                emit_cnt  <= emit_cnt + 1'b1;
            end else if (emit_fill) begin
                out_data  <= {1'b0, PAD_CHAR};
                out_valid <= 1'b1;
                emit_cnt  <= emit_cnt + 1'b1;
            end else if (out_take) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
